// File: rtl/collision_scheduler_if.sv
// ---------------------------------------------------------------------------
// collision_scheduler_if
//   Bundles the signals between the collision scheduler, the sprite position
//   registers, the shared collision comparator and the game-state controller.
//   master : the scheduler side (takes positions and cmp_hit, drives the
//            cmp_* operands and the scan results)
//   slave  : the surrounding logic (drives positions and controls, and
//            receives the operands and results)
// ---------------------------------------------------------------------------
interface collision_scheduler_if #(
   parameter int NUM_GHOSTS = 4,
   parameter int X_W        = 11,
   parameter int Y_W        = 10
);
   logic                      game_active;
   logic                      frame_tick;
   logic [X_W-1:0]            pacman_pos_x;
   logic [Y_W-1:0]            pacman_pos_y;
   logic [NUM_GHOSTS*X_W-1:0] ghost_pos_x;
   logic [NUM_GHOSTS*Y_W-1:0] ghost_pos_y;
   logic [NUM_GHOSTS-1:0]     fright_mask;
   logic                      dead_clear;
   logic [X_W-1:0]            cmp_ghost_x;
   logic [Y_W-1:0]            cmp_ghost_y;
   logic [X_W-1:0]            cmp_pacman_x;
   logic [Y_W-1:0]            cmp_pacman_y;
   logic                      cmp_hit;
   logic                      busy;
   logic                      scan_done;
   logic [NUM_GHOSTS-1:0]     hit_mask;
   logic [NUM_GHOSTS-1:0]     ghost_eaten;
   logic                      death_pulse;
   logic                      pacman_dead;
   logic                      tick_overrun;

   modport master (
      input  game_active, frame_tick, pacman_pos_x, pacman_pos_y,
             ghost_pos_x, ghost_pos_y, fright_mask, dead_clear, cmp_hit,
      output cmp_ghost_x, cmp_ghost_y, cmp_pacman_x, cmp_pacman_y,
             busy, scan_done, hit_mask, ghost_eaten, death_pulse,
             pacman_dead, tick_overrun
   );

   modport slave (
      output game_active, frame_tick, pacman_pos_x, pacman_pos_y,
             ghost_pos_x, ghost_pos_y, fright_mask, dead_clear, cmp_hit,
      input  cmp_ghost_x, cmp_ghost_y, cmp_pacman_x, cmp_pacman_y,
             busy, scan_done, hit_mask, ghost_eaten, death_pulse,
             pacman_dead, tick_overrun
   );
endinterface

// File: rtl/collision_scheduler.sv
// ---------------------------------------------------------------------------
// collision_scheduler
//   Shares one combinational collision comparator across all ghosts. On a
//   frame_tick (while game_active) the pacman/ghost positions and the
//   fright mask are snapshotted, then one ghost per cycle is presented on
//   cmp_*. The per-ghost hits are gathered and reported as either eaten
//   ghosts (frightened) or a pacman death (any non-frightened hit).
// Ports
//   clka   : system clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every register
//   bus    : collision_scheduler_if.master (positions, controls, comparator
//            operands/result, scan results and status)
// ---------------------------------------------------------------------------
module collision_scheduler #(
   parameter int NUM_GHOSTS = 4,
   parameter int X_W        = 11,
   parameter int Y_W        = 10
) (
   input logic                   clka,
   input logic                   rst_n,
   collision_scheduler_if.master bus
);
   localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      CHECK  = 2'd2,
      REPORT = 2'd3
   } state_t;

   state_t                    state_r;
   state_t                    state_next_s;
   logic                      report_s;
   logic [IDX_W-1:0]          idx_r;
   logic [IDX_W-1:0]          idx_inc_s;

   logic [X_W-1:0]            snap_pac_x_r;
   logic [Y_W-1:0]            snap_pac_y_r;
   logic [NUM_GHOSTS*X_W-1:0] snap_gx_r;
   logic [NUM_GHOSTS*Y_W-1:0] snap_gy_r;
   logic [NUM_GHOSTS-1:0]     snap_fright_r;
   logic [NUM_GHOSTS-1:0]     work_r;

   logic [X_W-1:0]            cmp_ghost_x_r;
   logic [Y_W-1:0]            cmp_ghost_y_r;
   logic [X_W-1:0]            cmp_pacman_x_r;
   logic [Y_W-1:0]            cmp_pacman_y_r;
   logic                      busy_r;
   logic                      scan_done_r;
   logic [NUM_GHOSTS-1:0]     hit_mask_r;
   logic [NUM_GHOSTS-1:0]     ghost_eaten_r;
   logic                      death_pulse_r;
   logic                      pacman_dead_r;
   logic                      tick_overrun_r;

   assign idx_inc_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};

   // State register.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a drop of game_active abandons any scan in flight.
   always_comb begin
      state_next_s = state_r;
      report_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.frame_tick && bus.game_active) begin
               state_next_s = LOAD;
            end else begin
               state_next_s = IDLE;
            end
         end
         LOAD: begin
            if (!bus.game_active) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = CHECK;
            end
         end
         CHECK: begin
            if (!bus.game_active) begin
               state_next_s = IDLE;
            end else if (idx_r == LAST_IDX) begin
               state_next_s = REPORT;
            end else begin
               state_next_s = CHECK;
            end
         end
         REPORT: begin
            state_next_s = IDLE;
            report_s     = bus.game_active;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Snapshot, operand sequencing, hit collection and result registers.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         idx_r          <= {IDX_W{1'b0}};
         snap_pac_x_r   <= {X_W{1'b0}};
         snap_pac_y_r   <= {Y_W{1'b0}};
         snap_gx_r      <= {(NUM_GHOSTS*X_W){1'b0}};
         snap_gy_r      <= {(NUM_GHOSTS*Y_W){1'b0}};
         snap_fright_r  <= {NUM_GHOSTS{1'b0}};
         work_r         <= {NUM_GHOSTS{1'b0}};
         cmp_ghost_x_r  <= {X_W{1'b0}};
         cmp_ghost_y_r  <= {Y_W{1'b0}};
         cmp_pacman_x_r <= {X_W{1'b0}};
         cmp_pacman_y_r <= {Y_W{1'b0}};
         busy_r         <= 1'b0;
         scan_done_r    <= 1'b0;
         hit_mask_r     <= {NUM_GHOSTS{1'b0}};
         ghost_eaten_r  <= {NUM_GHOSTS{1'b0}};
         death_pulse_r  <= 1'b0;
         pacman_dead_r  <= 1'b0;
         tick_overrun_r <= 1'b0;
      end else begin
         busy_r         <= (state_next_s != IDLE);
         tick_overrun_r <= bus.frame_tick && (state_r != IDLE);
         scan_done_r    <= report_s;
         // A frightened ghost that is hit is only eaten, never lethal.
         ghost_eaten_r  <= report_s ? (work_r & snap_fright_r) : {NUM_GHOSTS{1'b0}};
         death_pulse_r  <= report_s && (|(work_r & ~snap_fright_r));
         if (report_s) begin
            hit_mask_r <= work_r;
         end
         // Set has priority over clear.
         pacman_dead_r <= death_pulse_r || (pacman_dead_r && !bus.dead_clear);

         case (state_r)
            IDLE: begin
               if (state_next_s == LOAD) begin
                  snap_pac_x_r  <= bus.pacman_pos_x;
                  snap_pac_y_r  <= bus.pacman_pos_y;
                  snap_gx_r     <= bus.ghost_pos_x;
                  snap_gy_r     <= bus.ghost_pos_y;
                  snap_fright_r <= bus.fright_mask;
               end
            end
            LOAD: begin
               idx_r          <= {IDX_W{1'b0}};
               cmp_ghost_x_r  <= snap_gx_r[X_W-1:0];
               cmp_ghost_y_r  <= snap_gy_r[Y_W-1:0];
               cmp_pacman_x_r <= snap_pac_x_r;
               cmp_pacman_y_r <= snap_pac_y_r;
            end
            CHECK: begin
               // cmp_hit reflects the operands registered on the previous edge.
               work_r[idx_r] <= bus.cmp_hit;
               if (idx_r != LAST_IDX) begin
                  idx_r         <= idx_inc_s;
                  cmp_ghost_x_r <= snap_gx_r[int'(idx_inc_s)*X_W +: X_W];
                  cmp_ghost_y_r <= snap_gy_r[int'(idx_inc_s)*Y_W +: Y_W];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.cmp_ghost_x  = cmp_ghost_x_r;
   assign bus.cmp_ghost_y  = cmp_ghost_y_r;
   assign bus.cmp_pacman_x = cmp_pacman_x_r;
   assign bus.cmp_pacman_y = cmp_pacman_y_r;
   assign bus.busy         = busy_r;
   assign bus.scan_done    = scan_done_r;
   assign bus.hit_mask     = hit_mask_r;
   assign bus.ghost_eaten  = ghost_eaten_r;
   assign bus.death_pulse  = death_pulse_r;
   assign bus.pacman_dead  = pacman_dead_r;
   assign bus.tick_overrun = tick_overrun_r;
endmodule

// File: tb/tb_collision_scheduler.sv
// ---------------------------------------------------------------------------
// tb_collision_scheduler
//   Directed bench for collision_scheduler. The collision comparator is
//   modelled as exact position equality of the presented operands.
// ---------------------------------------------------------------------------
module tb_collision_scheduler;
   localparam int NG = 4;
   localparam int XW = 11;
   localparam int YW = 10;

   logic clka  = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   n;
   int   cnt;

   collision_scheduler_if #(.NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW)) bus ();

   collision_scheduler #(.NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW)) dut (
      .clka  (clka),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clka = ~clka;

   assign bus.cmp_hit = (bus.cmp_ghost_x == bus.cmp_pacman_x) &&
                        (bus.cmp_ghost_y == bus.cmp_pacman_y);

   task automatic cyc();
      @(posedge clka);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_pac(input int x, input int y);
      bus.pacman_pos_x = x[XW-1:0];
      bus.pacman_pos_y = y[YW-1:0];
   endtask

   task automatic set_ghost(input int k, input int x, input int y);
      bus.ghost_pos_x[k*XW +: XW] = x[XW-1:0];
      bus.ghost_pos_y[k*YW +: YW] = y[YW-1:0];
   endtask

   task automatic set_all(input int x, input int y);
      for (int k = 0; k < NG; k++) set_ghost(k, x, y);
   endtask

   task automatic tick();
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
   endtask

   // Waits (bounded) for scan_done; lat counts edges since the tick edge.
   task automatic wait_done(input int start, output int lat);
      lat = start;
      while (!bus.scan_done && lat < 20) begin
         cyc();
         lat++;
      end
   endtask

   initial begin
      bus.game_active  = 1'b0;
      bus.frame_tick   = 1'b0;
      bus.dead_clear   = 1'b0;
      bus.fright_mask  = 4'b0000;
      bus.pacman_pos_x = 11'd0;
      bus.pacman_pos_y = 10'd0;
      bus.ghost_pos_x  = 44'd0;
      bus.ghost_pos_y  = 40'd0;

      #12;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_scan_done", 32'(bus.scan_done), 32'd0);
      chk("rst_hit_mask", 32'(bus.hit_mask), 32'd0);
      chk("rst_pacman_dead", 32'(bus.pacman_dead), 32'd0);
      chk("rst_cmp_ghost_x", 32'(bus.cmp_ghost_x), 32'd0);
      cyc();
      rst_n = 1'b1;
      bus.game_active = 1'b1;

      // 1: no collision
      set_pac(951, 466);
      set_all(791, 370);
      tick();
      chk("t1_busy", 32'(bus.busy), 32'd1);
      wait_done(0, n);
      chk("t1_latency", 32'(n), 32'd6);
      chk("t1_hit_mask", 32'(bus.hit_mask), 32'h0);
      chk("t1_death", 32'(bus.death_pulse), 32'd0);
      chk("t1_eaten", 32'(bus.ghost_eaten), 32'h0);
      cyc();
      chk("t1_done_pulse", 32'(bus.scan_done), 32'd0);
      chk("t1_dead", 32'(bus.pacman_dead), 32'd0);
      chk("t1_idle", 32'(bus.busy), 32'd0);
      chk("t1_cmp_hold_gx", 32'(bus.cmp_ghost_x), 32'd791);
      chk("t1_cmp_hold_px", 32'(bus.cmp_pacman_x), 32'd951);

      // 2: ghost 2 kills pacman
      set_pac(807, 402);
      set_ghost(2, 807, 402);
      tick();
      wait_done(0, n);
      chk("t2_latency", 32'(n), 32'd6);
      chk("t2_hit_mask", 32'(bus.hit_mask), 32'h4);
      chk("t2_death", 32'(bus.death_pulse), 32'd1);
      chk("t2_eaten", 32'(bus.ghost_eaten), 32'h0);
      cyc();
      chk("t2_dead", 32'(bus.pacman_dead), 32'd1);
      repeat (5) cyc();
      chk("t2_dead_sticky", 32'(bus.pacman_dead), 32'd1);
      bus.dead_clear = 1'b1;
      cyc();
      bus.dead_clear = 1'b0;
      chk("t2_dead_clear", 32'(bus.pacman_dead), 32'd0);

      // 3: ghost 2 frightened, eaten instead
      bus.fright_mask = 4'b0100;
      tick();
      wait_done(0, n);
      chk("t3_eaten", 32'(bus.ghost_eaten), 32'h4);
      chk("t3_death", 32'(bus.death_pulse), 32'd0);
      cyc();
      chk("t3_eaten_pulse", 32'(bus.ghost_eaten), 32'h0);
      chk("t3_dead", 32'(bus.pacman_dead), 32'd0);

      // 4: ghost 1 frightened eaten, ghost 2 kills
      set_ghost(1, 807, 402);
      bus.fright_mask = 4'b0010;
      tick();
      wait_done(0, n);
      chk("t4_hit_mask", 32'(bus.hit_mask), 32'h6);
      chk("t4_eaten", 32'(bus.ghost_eaten), 32'h2);
      chk("t4_death", 32'(bus.death_pulse), 32'd1);
      cyc();
      chk("t4_dead", 32'(bus.pacman_dead), 32'd1);
      tick();
      wait_done(0, n);
      chk("t4b_death", 32'(bus.death_pulse), 32'd1);
      bus.dead_clear = 1'b1;
      cyc();
      chk("t4b_set_wins", 32'(bus.pacman_dead), 32'd1);
      cyc();
      bus.dead_clear = 1'b0;
      chk("t4b_clear", 32'(bus.pacman_dead), 32'd0);

      // 5: overrun tick and mid-scan move are both ignored
      bus.fright_mask = 4'b0000;
      set_all(791, 370);
      set_pac(807, 402);
      tick();
      cyc();
      bus.frame_tick = 1'b1;
      set_ghost(2, 807, 402);
      cyc();
      bus.frame_tick = 1'b0;
      chk("t5_overrun", 32'(bus.tick_overrun), 32'd1);
      wait_done(2, n);
      chk("t5_latency", 32'(n), 32'd6);
      chk("t5_hit_mask", 32'(bus.hit_mask), 32'h0);
      chk("t5_death", 32'(bus.death_pulse), 32'd0);
      cnt = 0;
      repeat (12) begin
         cyc();
         if (bus.scan_done) cnt++;
      end
      chk("t5_single_done", 32'(cnt), 32'd0);
      chk("t5_overrun_low", 32'(bus.tick_overrun), 32'd0);

      // 6: abort by game_active, idle tick with game inactive, async reset
      set_all(791, 370);
      set_ghost(0, 807, 402);
      tick();
      cyc();
      bus.game_active = 1'b0;
      cyc();
      chk("t6_abort_idle", 32'(bus.busy), 32'd0);
      cnt = 0;
      repeat (10) begin
         cyc();
         if (bus.scan_done) cnt++;
      end
      chk("t6_no_done", 32'(cnt), 32'd0);
      chk("t6_hit_kept", 32'(bus.hit_mask), 32'h0);
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      chk("t6_inactive_busy", 32'(bus.busy), 32'd0);
      cyc();
      chk("t6_inactive_overrun", 32'(bus.tick_overrun), 32'd0);

      bus.game_active = 1'b1;
      tick();
      wait_done(0, n);
      chk("t6_hit_mask", 32'(bus.hit_mask), 32'h1);
      cyc();
      chk("t6_dead", 32'(bus.pacman_dead), 32'd1);
      tick();
      cyc();
      cyc();
      chk("t6_pre_busy", 32'(bus.busy), 32'd1);
      chk("t6_pre_cmp_px", 32'(bus.cmp_pacman_x), 32'd807);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(bus.busy), 32'd0);
      chk("t6_rst_dead", 32'(bus.pacman_dead), 32'd0);
      chk("t6_rst_hit_mask", 32'(bus.hit_mask), 32'h0);
      chk("t6_rst_cmp_px", 32'(bus.cmp_pacman_x), 32'd0);
      chk("t6_rst_cmp_py", 32'(bus.cmp_pacman_y), 32'd0);
      chk("t6_rst_cmp_gx", 32'(bus.cmp_ghost_x), 32'd0);
      chk("t6_rst_cmp_gy", 32'(bus.cmp_ghost_y), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
